uart_tx_arbiter: RTL

- Shares one uart_tx transmitter among N byte requesters using round-robin arbitration.
- Latches the winner's byte and frame config (length, parity, stop bits) and drives the transmitter's start/config inputs.
- Waits for frame completion, then applies an inter-frame gap.
- Sits in the clk domain between the requesters and the TX side. tx_done/tx_err arrive already synchronised to clk as single-cycle pulses.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/rr_picker.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] len;
    logic       parity_en;
    logic       parity_type;
    logic       stop2;
  } frame_cfg_t;

  localparam logic [3:0] MIN_LEN = 4'd5;
  localparam logic [3:0] MAX_LEN = 4'd8;

  // Illegal data lengths fall back to a full 8-bit frame.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return ((len >= MIN_LEN) && (len <= MAX_LEN)) ? len : MAX_LEN;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request found searching
// ptr, ptr+1, ... modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          valid
);

  // Candidate index at each search offset from the pointer.
  logic [IW-1:0] cand [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = IW'((int'(ptr) + gi) % N);
    end
  endgenerate

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        grant = cand[k];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte requesters.
// Optional macro UART_ARB_FIXED_PRIO_EN: requester 0 takes absolute priority,
// the remaining requesters rotate among themselves.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N          = 4,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*8-1:0]       req_data,
  input  logic [N*4-1:0]       req_len,
  input  logic [N-1:0]         req_parity_en,
  input  logic [N-1:0]         req_parity_type,
  input  logic [N-1:0]         req_stop2,
  output logic [N-1:0]         ack,
  output logic [N-1:0]         nak,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic [3:0]           length,
  output logic                 parity_en,
  output logic                 parity_type,
  output logic                 stop2,
  input  logic                 tx_done,
  input  logic                 tx_err,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  arb_state_t    state_reg;
  frame_cfg_t    cfg_reg;
  logic [IW-1:0] grant_reg;
  logic [IW-1:0] rr_ptr_reg;
  logic [IW-1:0] rr_ptr_next;
  logic [WW-1:0] wait_cnt_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic          tx_start_reg;
  logic          busy_reg;
  logic          timeout_err_reg;
  logic [N-1:0]  ack_reg;
  logic [N-1:0]  nak_reg;

  // Per-requester frame configuration with the length already sanitised.
  frame_cfg_t req_cfg [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cfg
      assign req_cfg[gi] = {req_data[8*gi +: 8], clamp_len(req_len[4*gi +: 4]),
                            req_parity_en[gi], req_parity_type[gi], req_stop2[gi]};
    end
  endgenerate

  logic [N-1:0]  pick_mask;
  logic [IW-1:0] pick_grant;
  logic          pick_valid;
  logic [IW-1:0] win_id;
  logic          win_valid;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Requester 0 bypasses the rotation; the picker only sees the others.
  assign pick_mask = {req[N-1:1], 1'b0};
  assign win_valid = req[0] | pick_valid;
  assign win_id    = req[0] ? '0 : pick_grant;
`else
  assign pick_mask = req;
  assign win_valid = pick_valid;
  assign win_id    = pick_grant;
`endif

  rr_picker #(.N(N)) u_picker (
    .req   (pick_mask),
    .ptr   (rr_ptr_reg),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Pointer moves just past the owner of the frame that just finished.
  always_comb begin
    rr_ptr_next = (int'(grant_reg) == N - 1) ? '0 : grant_reg + 1'b1;
`ifdef UART_ARB_FIXED_PRIO_EN
    if (rr_ptr_next == '0) rr_ptr_next = IW'(1);
`endif
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cfg_reg         <= '0;
      grant_reg       <= '0;
      rr_ptr_reg      <= '0;
      wait_cnt_reg    <= '0;
      gap_cnt_reg     <= '0;
      tx_start_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      ack_reg         <= '0;
      nak_reg         <= '0;
    end else begin
      ack_reg <= '0;
      nak_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            cfg_reg   <= req_cfg[win_id];
            grant_reg <= win_id;
            busy_reg  <= 1'b1;
            state_reg <= START;
          end
        end
        START: begin
          tx_start_reg <= 1'b1;
          wait_cnt_reg <= '0;
          state_reg    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_err || tx_done || (wait_cnt_reg == WW'(TIMEOUT - 1))) begin
            // An error pulse outranks a simultaneous done pulse.
            if (tx_done && !tx_err) ack_reg <= N'(1) << grant_reg;
            else                    nak_reg <= N'(1) << grant_reg;
            if (!tx_err && !tx_done) timeout_err_reg <= 1'b1;
            tx_start_reg <= 1'b0;
            rr_ptr_reg   <= rr_ptr_next;
            gap_cnt_reg  <= '0;
            state_reg    <= GAP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GW'(GAP_CYCLES - 1)) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ack         = ack_reg;
  assign nak         = nak_reg;
  assign tx_start    = tx_start_reg;
  assign tx_data     = cfg_reg.data;
  assign length      = cfg_reg.len;
  assign parity_en   = cfg_reg.parity_en;
  assign parity_type = cfg_reg.parity_type;
  assign stop2       = cfg_reg.stop2;
  assign grant_id    = grant_reg;
  assign busy        = busy_reg;
  assign timeout_err = timeout_err_reg;

endmodule
